// File: rtl/perf_ctr_pkg.sv
// Shared constants, register-select types and the address decode for the
// performance-counter bank.
package perf_ctr_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_EN       = 8'h04;
  localparam logic [7:0] OFF_OVF      = 8'h08;
  localparam logic [7:0] OFF_THRESH   = 8'h0C;
  localparam logic [7:0] OFF_CTR_BASE = 8'h10;
  localparam logic [7:0] CTR_STRIDE   = 8'h08;

  localparam int unsigned CTRL_GEN = 0;
  localparam int unsigned CTRL_CLR = 1;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_EN,
    REG_OVF,
    REG_THRESH,
    REG_CTR_LO,
    REG_CTR_HI
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [3:0] idx;
  } reg_sel_t;

  // Counter i occupies OFF_CTR_BASE + i*CTR_STRIDE (low) and +4 (high).
  function automatic reg_sel_t reg_decode(input logic [7:0] addr,
                                          input int unsigned num_ctrs);
    reg_sel_t    sel;
    logic [7:0]  word;
    logic [7:0]  off;
    int unsigned slot;
    word     = {addr[7:2], 2'b00};
    off      = '0;
    slot     = 0;
    sel.kind = REG_NONE;
    sel.idx  = '0;
    case (word)
      OFF_CTRL:   sel.kind = REG_CTRL;
      OFF_EN:     sel.kind = REG_EN;
      OFF_OVF:    sel.kind = REG_OVF;
      OFF_THRESH: sel.kind = REG_THRESH;
      default: begin
        if (word >= OFF_CTR_BASE) begin
          off  = word - OFF_CTR_BASE;
          slot = 32'(off) / 32'(CTR_STRIDE);
          if (slot < num_ctrs) begin
            sel.idx  = 4'(slot);
            sel.kind = off[2] ? REG_CTR_HI : REG_CTR_LO;
          end
        end
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/perf_ctr_bank_if.sv
// Request/response bus between the X-stage issue logic and the counter bank.
interface perf_ctr_bank_if;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output rsp_rdata
  );
endinterface

// File: rtl/perf_ctr_cell.sv
// One WIDTH-bit event counter: clear beats word write beats increment;
// wrap pulses when an increment rolls the counter over from all-ones.
module perf_ctr_cell
  import perf_ctr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [31:0]      wdata,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;

  if (WIDTH > 32) begin : g_wide
    localparam int unsigned HI_W = WIDTH - 32;
    always_comb begin
      nxt = cnt;
      if (wr_lo)
        nxt[31:0] = wdata;
      else if (wr_hi)
        nxt[WIDTH-1:32] = HI_W'(wdata);
    end
  end else begin : g_narrow
    always_comb nxt = wr_lo ? wdata : cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (wr_lo || wr_hi)
      cnt <= nxt;
    else if (inc)
      cnt <= cnt + WIDTH'(1);
  end

  assign wrap  = inc && !clr && !wr_lo && !wr_hi && (&cnt);
  assign value = cnt;

endmodule

// File: rtl/perf_ctr_bank.sv
// Memory-mapped bank of NUM_CTRS event counters with sticky overflow flags
// and a shared high-word shadow. Optional threshold IRQ: PERF_CTR_THRESH_EN.
module perf_ctr_bank
  import perf_ctr_pkg::*;
#(
  parameter int unsigned         NUM_CTRS    = 4,
  parameter int unsigned         CTR_WIDTH   = 32,
  parameter logic [NUM_CTRS-1:0] RST_EN_MASK = NUM_CTRS'(4'b0011)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall,
  input  logic [NUM_CTRS-1:0] event_i,
  perf_ctr_bank_if.slave      bus,
  output logic [NUM_CTRS-1:0] ovf_o
`ifdef PERF_CTR_THRESH_EN
  ,
  output logic                thresh_irq
`endif
);

  reg_sel_t             sel;
  logic                 accept;
  logic                 wr;
  logic                 rd;
  logic                 clr_all;
  logic                 gen;
  logic [NUM_CTRS-1:0]  en;
  logic [NUM_CTRS-1:0]  ovf;
  logic [NUM_CTRS-1:0]  ovf_w1c;
  logic [NUM_CTRS-1:0]  wrap;
  logic [31:0]          shadow;
  logic [31:0]          rdata_q;
  logic [31:0]          rdata_nxt;
  logic [CTR_WIDTH-1:0] cnt_val [NUM_CTRS];
  logic [CTR_WIDTH-1:0] sel_cnt;
  logic [31:0]          lo_sel;
  logic [31:0]          hi_sel;

  assign sel     = reg_decode(bus.req_addr, NUM_CTRS);
  assign accept  = bus.req_valid && !stall;
  assign wr      = accept && bus.req_we;
  assign rd      = accept && !bus.req_we;
  assign clr_all = wr && (sel.kind == REG_CTRL) && bus.req_wdata[CTRL_CLR];
  assign ovf_w1c = (wr && (sel.kind == REG_OVF)) ? bus.req_wdata[NUM_CTRS-1:0] : '0;

  for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
    perf_ctr_cell #(
      .WIDTH (CTR_WIDTH)
    ) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (gen && en[i] && event_i[i] && !stall),
      .clr     (clr_all),
      .wr_lo   (wr && (sel.kind == REG_CTR_LO) && (sel.idx == 4'(i))),
      .wr_hi   (wr && (sel.kind == REG_CTR_HI) && (sel.idx == 4'(i)) && (CTR_WIDTH > 32)),
      .wdata   (bus.req_wdata),
      .value   (cnt_val[i]),
      .wrap    (wrap[i])
    );
  end

  always_comb begin
    sel_cnt = '0;
    for (int unsigned i = 0; i < NUM_CTRS; i++)
      if (sel.idx == 4'(i))
        sel_cnt = cnt_val[i];
  end

  if (CTR_WIDTH > 32) begin : g_hi
    assign lo_sel = sel_cnt[31:0];
    assign hi_sel = 32'(sel_cnt[CTR_WIDTH-1:32]);
  end else begin : g_no_hi
    assign lo_sel = sel_cnt;
    assign hi_sel = '0;
  end

`ifdef PERF_CTR_THRESH_EN
  logic [31:0] thresh_q;
  logic [31:0] ctr1_lo;

  if (NUM_CTRS > 1) begin : g_ctr1
    assign ctr1_lo = cnt_val[1][31:0];
  end else begin : g_no_ctr1
    assign ctr1_lo = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      thresh_q   <= '1;
      thresh_irq <= 1'b0;
    end else begin
      if (wr && (sel.kind == REG_THRESH))
        thresh_q <= bus.req_wdata;
      thresh_irq <= gen && (ctr1_lo >= thresh_q);
    end
  end
`endif

  always_comb begin
    rdata_nxt = '0;
    case (sel.kind)
      REG_CTRL:   rdata_nxt[CTRL_GEN] = gen;
      REG_EN:     rdata_nxt = 32'(en);
      REG_OVF:    rdata_nxt = 32'(ovf);
`ifdef PERF_CTR_THRESH_EN
      REG_THRESH: rdata_nxt = thresh_q;
`endif
      REG_CTR_LO: rdata_nxt = lo_sel;
      REG_CTR_HI: rdata_nxt = (CTR_WIDTH > 32) ? shadow : '0;
      default:    rdata_nxt = '0;
    endcase
  end

  // A wrap in the same edge as a W1C wins, so the event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen     <= 1'b1;
      en      <= RST_EN_MASK;
      ovf     <= '0;
      shadow  <= '0;
      rdata_q <= '0;
    end else begin
      if (wr && (sel.kind == REG_CTRL))
        gen <= bus.req_wdata[CTRL_GEN];
      if (wr && (sel.kind == REG_EN))
        en <= bus.req_wdata[NUM_CTRS-1:0];
      if (clr_all)
        ovf <= '0;
      else
        ovf <= (ovf & ~ovf_w1c) | wrap;
      if (rd && (sel.kind == REG_CTR_LO))
        shadow <= hi_sel;
      if (rd)
        rdata_q <= rdata_nxt;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign ovf_o         = ovf;

endmodule

// File: doc/perf_ctr_bank.md
Name: perf_ctr_bank

Overview:
- Parametrised, memory-mapped performance-counter bank for the 3-stage RV32 core.
- Generalises the core's fixed cycle and instruction counters to NUM_CTRS counters of CTR_WIDTH bits each, with per-counter enable, sticky overflow flags and atomic split reads of wide counters.
- Sits beside the data-cache port: the X stage issues the request, and read data returns for the WB-stage mux one cycle later.

Parameters:
- NUM_CTRS, 4, number of counters (1..16); counter 0 is the cycle counter, counter 1 is instructions retired.
- CTR_WIDTH, 32, counter width in bits (32..64); bits above 31 are read through the high word.
- RST_EN_MASK, 4'b0011, enable mask loaded at reset (NUM_CTRS bits).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  pipeline stall; suspends event counting and request acceptance
- event_i  in  NUM_CTRS  per-cycle event pulses; event_i[0] is tied high by the integrator
- req_valid  in  1  access request in X stage
- req_we  in  1  1 = write, 0 = read
- req_addr  in  8  byte offset within the bank; bits [1:0] ignored
- req_wdata  in  32  write data
- rsp_rdata  out  32  read data, valid the cycle after acceptance
- ovf_o  out  NUM_CTRS  sticky overflow flags

Behaviour:
- Register map (offset):
  - 0x00 CTRL: bit0 GEN (global enable, reset 1); bit1 CLR (write 1 clears all counters and overflow flags, self-clearing, reads 0).
  - 0x04 EN: per-counter enable, reset RST_EN_MASK.
  - 0x08 OVF: sticky flags; writing 1 to a bit clears it.
  - 0x10+8*i: counter i low word.
  - 0x14+8*i: counter i high word, served from the shadow register.
- Unmapped offsets, and high words when CTR_WIDTH=32: reads return 0, writes are ignored.
- Accept condition: req_valid && !stall. A request during stall is ignored, with no side effects.
- Count condition: counter i increments by 1 on a clock edge when GEN && EN[i] && event_i[i] && !stall.
- Wrap: on increment from all-ones, counter i goes to 0 and OVF[i] sets in the same edge.
- Precedence within one edge, highest first:
  1. CLR.
  2. Direct write to counter i's word (the written half takes req_wdata; the other half is unchanged; no increment that cycle).
  3. Increment.
  - A W1C to OVF[i] coincident with a wrap of counter i leaves OVF[i] set.
- Atomic wide read: an accepted read of counter i's low word captures bits [CTR_WIDTH-1:32] of the pre-increment value into a single shared shadow register. A later high-word read of any counter returns the shadow, zero-extended.
- Read latency: rsp_rdata is registered and updated only on an accepted read. It holds its value otherwise (stall, write, idle).
- A read returns the counter value before that edge's increment.
- Reset (asynchronous assert, synchronous deassert handled by the integrator):
  - all counters, OVF, shadow and rsp_rdata = 0;
  - GEN = 1; EN = RST_EN_MASK.
  - Reset asserted mid-access discards the access.
- ovf_o equals OVF directly (combinational from the flops).

Optional Feature:
- Macro PERF_CTR_THRESH_EN.
- When defined:
  - adds output thresh_irq (1 bit) and register 0x0C THRESH (32 bits, reset 0xFFFF_FFFF);
  - thresh_irq is a registered, level output that is 1 while GEN && (counter 1 low word >= THRESH);
  - thresh_irq resets to 0.
- When undefined: no THRESH register, 0x0C reads 0, no thresh_irq port.

Decomposition:
- Package perf_ctr_pkg holds:
  - register offset constants (OFF_CTRL, OFF_EN, OFF_OVF, OFF_THRESH, OFF_CTR_BASE, CTR_STRIDE);
  - CTRL bit indices;
  - the counter-index decode function.
- One sub-module, perf_ctr_cell: a single CTR_WIDTH counter with inc, clr, lo/hi write strobes and a wrap pulse. Instantiate it NUM_CTRS times in a generate loop.

Test Plan:
1. Reset release, event_i=4'b0001, 10 unstalled cycles, read 0x10 → rsp_rdata=10 one cycle after the request; EN reads 0x3; OVF reads 0.
2. stall=1 for 5 of 20 cycles with event_i[0]=1 → counter 0 = 15; a read request issued during stall leaves rsp_rdata unchanged.
3. CTR_WIDTH=64: write counter 2 low 0xFFFF_FFFF and high 0x0000_0001, pulse event_i[2] once, read 0x20 then 0x24 → 0x0000_0000 then 0x0000_0002.
4. CTR_WIDTH=32: write counter 3 = 0xFFFF_FFFF, EN=0xF, one event → counter 3 = 0, OVF=0x8, ovf_o[3]=1. Write 0x8 to OVF → 0. W1C coincident with a wrap → flag stays 1.
5. Write CTRL=0x3 while event_i=4'b1111 → all counters 0 and OVF 0 the next cycle (CLR beats increment); CTRL reads 0x1.
6. PERF_CTR_THRESH_EN defined: THRESH=5, retire 5 instructions → thresh_irq rises the cycle after counter 1 reaches 5. Write GEN=0 → thresh_irq=0 the next cycle.
